// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped 2-bit BHT plus tagged BTB, with a registered redirect pulse.
// Define BRANCH_PRED_STATS_EN to add resolve/mispredict statistics counters.
module branch_predictor #(
  parameter int IDX_BITS     = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        fetch_valid_in,
  input  logic [31:0] fetch_pc_in,
  output logic        pred_taken_out,
  output logic [31:0] pred_target_out,
  input  logic        ex_valid_in,
  input  logic [31:0] ex_pc_in,
  input  logic [4:0]  ex_opcode_6_to_2_in,
  input  logic        ex_branch_taken_in,
  input  logic [31:0] ex_target_in,
  input  logic        ex_pred_taken_in,
  input  logic [31:0] ex_pred_target_in,
  output logic        mispredict_out,
  output logic [31:0] redirect_pc_out
`ifdef BRANCH_PRED_STATS_EN
  ,
  output logic [31:0] stat_resolved_out,
  output logic [31:0] stat_mispredict_out
`endif
);

  localparam int         ENTRIES   = 1 << IDX_BITS;
  localparam int         TAG_W     = 30 - IDX_BITS;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [3:0] FLUSH_LD  = 4'(FLUSH_CYCLES);

  logic [1:0]       ctr_q    [ENTRIES];
  logic [1:0]       ctr_d    [ENTRIES];
  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [31:0]      target_d [ENTRIES];

  logic [3:0]  squash_q, squash_d;
  logic        mispredict_q, mispredict_d;
  logic [31:0] redirect_q, redirect_d;

  logic [IDX_BITS-1:0] f_idx, x_idx;
  logic [TAG_W-1:0]    f_tag, x_tag;
  logic                is_ctrl, accept, actual, mispredict;

  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  assign f_idx = fetch_pc_in[IDX_BITS+1:2];
  assign f_tag = fetch_pc_in[31:IDX_BITS+2];
  assign x_idx = ex_pc_in[IDX_BITS+1:2];
  assign x_tag = ex_pc_in[31:IDX_BITS+2];

  // Lookup sees only registered table state, so a same-cycle update is not forwarded.
  assign pred_taken_out  = fetch_valid_in & valid_q[f_idx] & (tag_q[f_idx] == f_tag)
                           & ctr_q[f_idx][1];
  assign pred_target_out = pred_taken_out ? target_q[f_idx] : fetch_pc_in + 32'd4;

  always_comb begin
    is_ctrl    = (ex_opcode_6_to_2_in == OP_BRANCH) | (ex_opcode_6_to_2_in == OP_JAL)
                 | (ex_opcode_6_to_2_in == OP_JALR);
    accept     = ex_valid_in & is_ctrl & (squash_q == 4'd0);
    actual     = (ex_opcode_6_to_2_in == OP_BRANCH) ? ex_branch_taken_in : 1'b1;
    mispredict = accept & ((actual != ex_pred_taken_in)
                 | (actual & ex_pred_taken_in & (ex_target_in != ex_pred_target_in)));
  end

  always_comb begin
    ctr_d        = ctr_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    target_d     = target_q;
    squash_d     = (squash_q != 4'd0) ? squash_q - 4'd1 : 4'd0;
    mispredict_d = mispredict;
    redirect_d   = redirect_q;
    if (accept) begin
      ctr_d[x_idx] = ctr_step(ctr_q[x_idx], actual);
      if (actual) begin
        valid_d[x_idx]  = 1'b1;
        tag_d[x_idx]    = x_tag;
        target_d[x_idx] = ex_target_in;
      end
    end
    if (mispredict) begin
      squash_d   = FLUSH_LD;
      redirect_d = actual ? ex_target_in : ex_pc_in + 32'd4;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i]   <= 2'b01;
        valid_q[i] <= 1'b0;
      end
      squash_q     <= 4'd0;
      mispredict_q <= 1'b0;
      redirect_q   <= 32'd0;
    end else begin
      ctr_q        <= ctr_d;
      valid_q      <= valid_d;
      squash_q     <= squash_d;
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
    end
  end

  // Tag and target are qualified by valid, so they need no reset.
  always_ff @(posedge clk_in) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  assign mispredict_out  = mispredict_q;
  assign redirect_pc_out = redirect_q;

`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] stat_res_q, stat_res_d, stat_mis_q, stat_mis_d;

  always_comb begin
    stat_res_d = stat_res_q + {31'd0, accept};
    stat_mis_d = stat_mis_q + {31'd0, mispredict};
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stat_res_q <= 32'd0;
      stat_mis_q <= 32'd0;
    end else begin
      stat_res_q <= stat_res_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign stat_resolved_out   = stat_res_q;
  assign stat_mispredict_out = stat_mis_q;
`endif

endmodule
